// File: rtl/deal_scheduler.sv
// deal_scheduler: deals cards from a deck to round-robin arbitrated players.
// One card per ARB -> DRAW -> WAIT -> DELIVER pass. A round ends when the
// deck runs dry, the round's card budget is used up, every hand is full,
// or the deck stops answering.
module deal_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int HAND_MAX    = 5,
  parameter int DECK_SIZE   = 54,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] player_req,
  output logic                   deck_draw,
  input  logic [5:0]             deck_card,
  input  logic                   deck_valid,
  input  logic                   deck_empty,
  output logic [NUM_PLAYERS-1:0] grant,
  output logic [5:0]             card_out,
  output logic                   card_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err_timeout
);

  localparam int HW = $clog2(HAND_MAX + 1);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [HW-1:0] HAND_LIMIT  = HW'(HAND_MAX);
  localparam logic [5:0]    DECK_LIMIT  = 6'(DECK_SIZE);
  localparam logic [PW-1:0] LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  // The draw-pulse cycle counts as the first cycle of the response window,
  // so WAIT itself lasts TIMEOUT-1 cycles before giving up.
  localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    DRAW,
    WAIT,
    DELIVER,
    DONE
  } state_t;

  state_t          state;
  logic [HW-1:0]   hand_cnt [NUM_PLAYERS];
  logic [5:0]      dealt_cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [TW-1:0]   wait_cnt;

  logic [NUM_PLAYERS-1:0] eligible;
  logic                   found;
  logic [PW-1:0]          pick;
  logic [PW-1:0]          ptr_next;
  logic                   all_full_after;
  logic                   round_over;
  int                     rr_idx;

  // A player may receive a card only while requesting and below the hand limit.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      eligible[p] = player_req[p] && (hand_cnt[p] < HAND_LIMIT);
    end
  end

  // Round-robin search starting at the pointer, wrapping to the lowest index.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      rr_idx = int'(ptr) + i;
      if (rr_idx >= NUM_PLAYERS) begin
        rr_idx = rr_idx - NUM_PLAYERS;
      end
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        pick  = PW'(rr_idx);
      end
    end
  end

  // Pointer moves just past the player being served, modulo the player count.
  always_comb begin
    ptr_next = (winner == LAST_PLAYER) ? '0 : winner + PW'(1);
  end

  // Decide in DELIVER whether the round ends, counting the card being delivered.
  always_comb begin
    all_full_after = 1'b1;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (p == int'(winner)) begin
        if (hand_cnt[p] + HW'(1) != HAND_LIMIT) begin
          all_full_after = 1'b0;
        end
      end else if (hand_cnt[p] != HAND_LIMIT) begin
        all_full_after = 1'b0;
      end
    end
    round_over = (dealt_cnt + 6'd1 >= DECK_LIMIT) || deck_empty || all_full_after;
  end

  // Main controller: state, counters and every output are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      winner      <= '0;
      dealt_cnt   <= '0;
      wait_cnt    <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        hand_cnt[p] <= '0;
      end
      deck_draw   <= 1'b0;
      grant       <= '0;
      card_out    <= '0;
      card_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      deck_draw  <= 1'b0;
      card_valid <= 1'b0;
      grant      <= '0;
      card_out   <= '0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= ARB;
            busy        <= 1'b1;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            dealt_cnt   <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              hand_cnt[p] <= '0;
            end
          end
        end

        ARB: begin
          if (deck_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (found) begin
            winner    <= pick;
            state     <= DRAW;
            deck_draw <= 1'b1;
          end
        end

        DRAW: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        WAIT: begin
          if (deck_valid) begin
            state      <= DELIVER;
            card_valid <= 1'b1;
            grant      <= NUM_PLAYERS'(1) << winner;
            card_out   <= deck_card;
          end else if (wait_cnt >= WAIT_LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end

        DELIVER: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (p == int'(winner) && hand_cnt[p] < HAND_LIMIT) begin
              hand_cnt[p] <= hand_cnt[p] + HW'(1);
            end
          end
          if (dealt_cnt < DECK_LIMIT) begin
            dealt_cnt <= dealt_cnt + 6'd1;
          end
          ptr <= ptr_next;
          if (round_over) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ARB;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deal_scheduler.sv
// tb_deal_scheduler: directed scoreboard bench for deal_scheduler.
// Stimulus pushes expected deliveries into a queue; a monitor pops and
// compares on every card_valid. A small deck model answers draw pulses.
module tb_deal_scheduler;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] player_req;
  logic       deck_draw;
  logic [5:0] deck_card;
  logic       deck_valid;
  logic       deck_empty;
  logic [3:0] grant;
  logic [5:0] card_out;
  logic       card_valid;
  logic       busy;
  logic       done;
  logic       err_timeout;

  typedef struct packed {
    logic [3:0] g;
    logic [5:0] c;
  } exp_t;

  exp_t       exp_q [$];
  logic [5:0] deck_q [$];
  logic       deck_respond;
  logic       empty_when_drained;
  logic       mon_en;

  int errors;
  int checks;
  int cyc;
  int draw_cnt;
  int valid_cnt;
  int arb_cyc;
  int draw_cyc;
  int valid_cyc;
  int done_cyc;
  logic busy_prev;
  logic done_prev;

  deal_scheduler #(
    .NUM_PLAYERS(4),
    .HAND_MAX(5),
    .DECK_SIZE(54),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .player_req(player_req),
    .deck_draw(deck_draw),
    .deck_card(deck_card),
    .deck_valid(deck_valid),
    .deck_empty(deck_empty),
    .grant(grant),
    .card_out(card_out),
    .card_valid(card_valid),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Deck model: answers a draw with the next card one cycle after the pulse.
  initial begin
    deck_valid = 1'b0;
    deck_card  = '0;
    forever begin
      @(negedge clk);
      if (deck_draw && deck_respond && deck_q.size() > 0) begin
        @(posedge clk);
        #1;
        deck_valid = 1'b1;
        deck_card  = deck_q.pop_front();
        if (deck_q.size() == 0 && empty_when_drained) deck_empty = 1'b1;
        @(posedge clk);
        #1;
        deck_valid = 1'b0;
        deck_card  = '0;
      end
    end
  end

  // Monitor: scoreboard pops on delivery, zero checks otherwise, event timestamps.
  initial begin
    busy_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (card_valid) begin
          valid_cnt = valid_cnt + 1;
          valid_cyc = cyc;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_delivery", {28'd0, grant}, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("deliver_grant", {28'd0, grant}, {28'd0, e.g});
            checkOutput("deliver_card", {26'd0, card_out}, {26'd0, e.c});
          end
        end else begin
          checkOutput("idle_grant_card_zero", {22'd0, grant, card_out}, 32'd0);
        end
        if (deck_draw) begin
          draw_cnt = draw_cnt + 1;
          draw_cyc = cyc;
        end
        if (busy && !busy_prev) arb_cyc = cyc;
        if (done && !done_prev) done_cyc = cyc;
      end
      busy_prev = busy;
      done_prev = done;
    end
  end

  task automatic applyReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    player_req = '0;
    deck_empty = 1'b0;
    deck_respond = 1'b1;
    empty_when_drained = 1'b0;
    deck_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    draw_cnt = 0;
    valid_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    @(posedge clk);
    #1;
    player_req = req;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int maxc);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput(name, {31'd0, done}, 32'd1);
  endtask

  task automatic waitDelivered(input string name, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput(name, exp_q.size(), 32'd0);
  endtask

  // Global bound so a stuck DUT can never hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    errors = 0;
    checks = 0;
    draw_cnt = 0;
    valid_cnt = 0;
    arb_cyc = 0;
    draw_cyc = 0;
    valid_cyc = 0;
    done_cyc = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    player_req = '0;
    deck_empty = 1'b0;
    deck_respond = 1'b1;
    empty_when_drained = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("reset_outputs",
                {22'd0, deck_draw, grant, card_out, card_valid, busy, done, err_timeout},
                32'd0);
    mon_en = 1'b1;
    applyReset();
    @(negedge clk);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Single request: player 2, card 17, four-cycle latency.
    $display("[TB] single request");
    deck_q.push_back(6'd17);
    empty_when_drained = 1'b1;
    exp_q.push_back('{g: 4'b0100, c: 6'd17});
    applyStimulus(4'b0100);
    waitDelivered("single_delivered", 40);
    checkOutput("single_latency", valid_cyc - arb_cyc, 32'd3);
    waitDone("single_done", 20);
    checkOutput("single_draws", draw_cnt, 32'd1);

    // Fairness: everyone requesting, eight deliveries in rotation.
    $display("[TB] fairness");
    applyReset();
    for (int i = 0; i < 8; i++) begin
      logic [3:0] g;
      g = 4'b0001 << (i % 4);
      deck_q.push_back(6'(i + 1));
      exp_q.push_back('{g: g, c: 6'(i + 1)});
    end
    empty_when_drained = 1'b1;
    applyStimulus(4'b1111);
    waitDelivered("fair_delivered", 200);
    waitDone("fair_done", 20);
    checkOutput("fair_draws", draw_cnt, 32'd8);

    // Hand limit: player 1 alone gets five cards, then the scheduler parks in ARB.
    $display("[TB] hand limit");
    applyReset();
    for (int i = 0; i < 7; i++) deck_q.push_back(6'(10 + i));
    for (int i = 0; i < 5; i++) exp_q.push_back('{g: 4'b0010, c: 6'(10 + i)});
    applyStimulus(4'b0010);
    waitDelivered("limit_delivered", 200);
    repeat (10) @(negedge clk);
    checkOutput("limit_draws", draw_cnt, 32'd5);
    checkOutput("limit_busy", {31'd0, busy}, 32'd1);
    checkOutput("limit_done", {31'd0, done}, 32'd0);
    // A start while busy must not reopen the hands.
    applyStimulus(4'b0010);
    repeat (10) @(negedge clk);
    checkOutput("busy_start_draws", draw_cnt, 32'd5);
    checkOutput("busy_start_busy", {31'd0, busy}, 32'd1);

    // Timeout: deck never answers.
    $display("[TB] timeout");
    applyReset();
    deck_respond = 1'b0;
    applyStimulus(4'b0001);
    waitDone("timeout_done", 100);
    checkOutput("timeout_delay", done_cyc - draw_cyc, 32'd15);
    checkOutput("timeout_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("timeout_busy", {31'd0, busy}, 32'd0);
    checkOutput("timeout_draws", draw_cnt, 32'd1);
    checkOutput("timeout_no_card", valid_cnt, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("timeout_sticky", {31'd0, err_timeout}, 32'd1);
    // Restart from DONE clears the error and deals normally.
    deck_respond = 1'b1;
    deck_q.push_back(6'd9);
    empty_when_drained = 1'b1;
    exp_q.push_back('{g: 4'b0001, c: 6'd9});
    applyStimulus(4'b0001);
    @(negedge clk);
    checkOutput("restart_err_cleared", {31'd0, err_timeout}, 32'd0);
    checkOutput("restart_done_cleared", {31'd0, done}, 32'd0);
    waitDelivered("restart_delivered", 40);
    waitDone("restart_done", 20);

    // Deck exhaustion after the third delivery.
    $display("[TB] deck exhaustion");
    applyReset();
    deck_q.push_back(6'd40);
    deck_q.push_back(6'd41);
    deck_q.push_back(6'd42);
    empty_when_drained = 1'b1;
    exp_q.push_back('{g: 4'b0001, c: 6'd40});
    exp_q.push_back('{g: 4'b0010, c: 6'd41});
    exp_q.push_back('{g: 4'b0001, c: 6'd42});
    applyStimulus(4'b0011);
    waitDelivered("exhaust_delivered", 100);
    waitDone("exhaust_done", 20);
    checkOutput("exhaust_done_timing", done_cyc - valid_cyc, 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("exhaust_draws", draw_cnt, 32'd3);

    // Empty deck seen in ARB ends the round with no draw.
    $display("[TB] empty in arb");
    applyReset();
    deck_empty = 1'b1;
    applyStimulus(4'b1111);
    waitDone("arb_empty_done", 20);
    checkOutput("arb_empty_draws", draw_cnt, 32'd0);
    checkOutput("arb_empty_err", {31'd0, err_timeout}, 32'd0);

    // Reset while waiting on the deck; a late deck_valid must be ignored.
    $display("[TB] mid-round reset");
    applyReset();
    deck_respond = 1'b0;
    applyStimulus(4'b0100);
    begin
      int n;
      n = 0;
      while (draw_cnt == 0 && n < 20) begin
        @(negedge clk);
        n = n + 1;
      end
    end
    checkOutput("midreset_drawn", draw_cnt, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                {22'd0, deck_draw, grant, card_out, card_valid, busy, done, err_timeout},
                32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    deck_valid = 1'b1;
    deck_card = 6'd33;
    @(posedge clk);
    #1;
    deck_valid = 1'b0;
    deck_card = '0;
    repeat (5) @(negedge clk);
    checkOutput("midreset_idle",
                {22'd0, deck_draw, grant, card_out, card_valid, busy, done, err_timeout},
                32'd0);
    checkOutput("midreset_no_card", valid_cnt, 32'd0);
    checkOutput("midreset_no_redraw", draw_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
